hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Parametrised hazard controller for the 5-stage pipelined CPU; replaces the fixed single-bubble hazard logic.
- Adds:
  - configurable load latency, handled by a multi-cycle stall FSM;
  - register-0 exemption and per-operand use qualifiers;
  - HI/LO interlock against a multi-cycle mult/div unit;
  - whole-pipeline freeze on data-memory wait;
  - saturating stall/flush performance counters.

Parameters:
- ADDR_W, 5: register-address width.
- LOAD_LAT, 1: total bubble cycles for a load-use hazard; legal range 1..15.
- MD_EN, 1: enables the mult/div HI/LO interlock. When 0, md_* inputs are ignored.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- id_rs  in  ADDR_W  Rs of instruction in IF/ID.
- id_rt  in  ADDR_W  Rt of instruction in IF/ID.
- id_uses_rs  in  1  ID instruction reads Rs.
- id_uses_rt  in  1  ID instruction reads Rt.
- id_uses_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo).
- ex_rt  in  ADDR_W  destination of instruction in ID/EX.
- ex_mem_read  in  1  ID/EX instruction is a load.
- jump  in  1  jump resolved in ID.
- branch  in  1  taken branch resolved in EX.
- md_start  in  1  one-cycle pulse: mult/div issued from EX.
- md_done  in  1  one-cycle pulse: HI/LO result written.
- dmem_stall  in  1  data memory not ready.
- perf_clr  in  1  clear both counters.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  zero IF/ID.
- id_ex_stall  out  1  hold ID/EX.
- id_ex_flush  out  1  insert bubble into ID/EX.
- ex_mem_stall  out  1  hold EX/MEM.
- stall_cycles  out  CNT_W  cycles with pc_stall=1.
- flush_cycles  out  CNT_W  cycles with if_id_flush=1.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high. While reset=1 all control outputs are 0; on the next edge state=RUN, load counter=0, md_busy=0, both perf counters=0.
- Control outputs are combinational from state and inputs. FSM, counters and md_busy are registered.
- Load-use hazard (luh) = ex_mem_read && ex_rt!=0 && ((id_uses_rs && ex_rt==id_rs) || (id_uses_rt && ex_rt==id_rt)).
- HI/LO hazard (hlh) = MD_EN && md_busy && id_uses_hilo && !md_done.
  - md_busy sets on md_start and clears on md_done.
  - md_start and md_done in the same cycle leaves md_busy=1.
- FSM states: RUN, LOAD_WAIT. lcnt is 4 bits.
  - RUN with luh and no branch: front stall this cycle. If LOAD_LAT>1, go to LOAD_WAIT with lcnt=LOAD_LAT-1.
  - LOAD_WAIT: front stall every cycle and decrement lcnt. At lcnt==1, go to RUN at the end of the cycle.
  - Total stall for a load-use hazard = exactly LOAD_LAT cycles.
- Front stall: pc_stall=1, if_id_stall=1, id_ex_flush=1. Applied for luh, LOAD_WAIT or hlh.
- Priority, highest first:
  1. reset.
  2. dmem_stall: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall all 1; all flushes 0; FSM, lcnt and md_busy frozen (md_done is still honoured).
  3. branch: if_id_flush=1, id_ex_flush=1, stalls 0; LOAD_WAIT aborts to RUN.
  4. front stall (luh, LOAD_WAIT or hlh).
  5. jump: if_id_flush=1.
- jump together with a front stall: no flush this cycle. The jump stays in ID and flushes when the stall releases.
- hlh releases in the same cycle md_done=1.
- id_ex_stall and ex_mem_stall are 1 only under dmem_stall.
- Perf counters:
  - Each increments by 1 per qualifying cycle and saturates at all-ones.
  - perf_clr zeroes both and takes priority over increment in that cycle.
  - Both counters count during dmem_stall.

Decomposition:
- Package cpu_hazard_pkg: FSM state encoding (RUN=0, LOAD_WAIT=1); REG_ZERO constant.
- Sub-module sat_counter: parameter CNT_W; inputs clk, reset, clr, inc; output count. Instantiated twice.

Test Plan:
- LOAD_LAT=1: lw $t0 in EX, ID reads $t0 as Rs → one cycle of pc_stall/if_id_stall/id_ex_flush=1, then 0. stall_cycles=1.
- LOAD_LAT=3: same hazard → stall exactly 3 cycles. The same hazard with ex_rt=0, or with id_uses_rs=0, gives no stall.
- LOAD_LAT=3: branch=1 in the 2nd stall cycle → if_id_flush=id_ex_flush=1, pc_stall=0; next cycle is back in RUN with no stall.
- md_start, then 4 idle cycles, then md_done, with id_uses_hilo=1 from cycle 2 → stall asserted in cycles 2..4; 0 in the md_done cycle.
- dmem_stall=1 for 2 cycles while in LOAD_WAIT with lcnt=2 → all four stalls=1 and no flush; after release, lcnt still 2.
- jump together with a load-use hazard → if_id_flush=0 during the stall cycle; 1 in the following cycle. flush_cycles=1.
- reset asserted mid-LOAD_WAIT → outputs 0 while reset=1; after release, state is RUN and both counters read 0.

Source files
------------

// File: rtl/cpu_hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
package cpu_hazard_pkg;

  // Hazard FSM state encoding.
  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } hz_state_e;

  // Register $zero is hard-wired, so it never creates a data hazard.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; the count holds once it reaches all-ones.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls of configurable
// length, HI/LO interlock, data-memory freeze, branch/jump flushes and
// stall/flush performance counters.
module hazard_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_EN    = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_uses_hilo,
  input  logic [ADDR_W-1:0] ex_rt,
  input  logic              ex_mem_read,
  input  logic              jump,
  input  logic              branch,
  input  logic              md_start,
  input  logic              md_done,
  input  logic              dmem_stall,
  input  logic              perf_clr,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cycles
);

  // LOAD_WAIT covers the bubbles after the first one, so it starts at LAT-1.
  localparam logic [3:0] LCNT_INIT = 4'(LOAD_LAT - 1);

  hz_state_e  state, state_nxt;
  logic [3:0] lcnt, lcnt_nxt;
  logic       md_busy, md_busy_nxt;
  logic       luh;
  logic       hlh;
  logic       front_stall;

  // Hazard detection on the instruction sitting in ID.
  always_comb begin
    luh = ex_mem_read && (ex_rt != ADDR_W'(REG_ZERO)) &&
          ((id_uses_rs && (ex_rt == id_rs)) || (id_uses_rt && (ex_rt == id_rt)));
    hlh = (MD_EN != 0) && md_busy && id_uses_hilo && !md_done;
    front_stall = luh || (state == LOAD_WAIT) || hlh;
  end

  // Prioritised pipeline controls and FSM next state.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    state_nxt    = state;
    lcnt_nxt     = lcnt;

    if (reset) begin
      // Everything held low; registers are reset in the state process.
    end else if (dmem_stall) begin
      // Freeze the whole pipeline and the FSM.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (branch) begin
      // A taken branch squashes the wrong-path work and aborts any load wait.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_nxt   = RUN;
    end else if (front_stall) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      if (state == RUN) begin
        if (luh && (LOAD_LAT > 1)) begin
          state_nxt = LOAD_WAIT;
          lcnt_nxt  = LCNT_INIT;
        end
      end else begin
        if (lcnt == 4'd1) begin
          state_nxt = RUN;
        end
        lcnt_nxt = lcnt - 4'd1;
      end
    end else if (jump) begin
      // A jump held behind a stall flushes only once the stall releases.
      if_id_flush = 1'b1;
    end
  end

  // HI/LO busy tracking; a new issue is ignored while memory freezes EX.
  always_comb begin
    md_busy_nxt = md_busy;
    if (MD_EN != 0) begin
      if (md_start && !dmem_stall) begin
        md_busy_nxt = 1'b1;
      end else if (md_done) begin
        md_busy_nxt = 1'b0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      lcnt    <= 4'd0;
      md_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      lcnt    <= lcnt_nxt;
      md_busy <= md_busy_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (if_id_flush),
    .count (flush_cycles)
  );

endmodule
